// File: rtl/sevenseg_scan_decoder.sv
// sevenseg_scan_decoder
// Readback monitor for a multiplexed, active-low 7-segment display bus.
// The scanned bus is registered and debounced, and each stable digit strobe
// is decoded back to a hex nibble. A complete word is published once every
// digit has been captured.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   digitselect  active-low one-hot digit strobe (NDIGITS wide)
//   segments     active-low segments, bit7..bit1 = a..g, bit0 = dp
//   value        last complete decoded word, digit i in value[4i+3:4i]
//   value_valid  one-cycle pulse when value updates
//   digit_err    per-digit "pattern did not decode" flags for the last frame
//   select_err   one-cycle pulse when a multi-hot strobe is accepted
//   dp_mask      (SEVENSEG_DP_CAPTURE_EN only) per-digit decimal point state
//
// Build option: define SEVENSEG_DP_CAPTURE_EN to add the dp_mask output.
module sevenseg_scan_decoder #(
    parameter int NDIGITS       = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NDIGITS-1:0]     digitselect,
    input  logic [7:0]             segments,
    output logic [4*NDIGITS-1:0]   value,
    output logic                   value_valid,
    output logic [NDIGITS-1:0]     digit_err,
    output logic                   select_err
`ifdef SEVENSEG_DP_CAPTURE_EN
    ,
    output logic [NDIGITS-1:0]     dp_mask
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [NDIGITS-1:0]   sel_q;
    logic [7:0]           seg_q;
    logic [CW-1:0]        stable_cnt, cnt_nxt;
    logic                 held;
    logic [NDIGITS-1:0]   captured, cap_nxt;
    logic [4*NDIGITS-1:0] shadow, shadow_nxt;
    logic [NDIGITS-1:0]   shadow_err, err_nxt;
    logic [NDIGITS-1:0]   shadow_dp, dp_nxt;
    logic                 frame_done, done_nxt;

    logic                 bus_same, accept, one_hot, multi_hot;
    logic [NDIGITS-1:0]   active;
    logic [4:0]           dec;

    // Returns {err, nibble}; active-high a..g pattern in, dp never enters.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'b1111110: decode_seg = 5'h00;
            7'b0110000: decode_seg = 5'h01;
            7'b1101101: decode_seg = 5'h02;
            7'b1111001: decode_seg = 5'h03;
            7'b0110011: decode_seg = 5'h04;
            7'b1011011: decode_seg = 5'h05;
            7'b1011111: decode_seg = 5'h06;
            7'b1110000: decode_seg = 5'h07;
            7'b1111111: decode_seg = 5'h08;
            7'b1111011: decode_seg = 5'h09;
            7'b1110111: decode_seg = 5'h0A;
            7'b0011111: decode_seg = 5'h0B;
            7'b1001110: decode_seg = 5'h0C;
            7'b0111101: decode_seg = 5'h0D;
            7'b1001111: decode_seg = 5'h0E;
            7'b1000111: decode_seg = 5'h0F;
            default:    decode_seg = 5'h10;
        endcase
    endfunction

    always_comb begin
        // Compare the pair about to be registered with the registered pair,
        // so a pattern first sampled at edge k is accepted at edge k+STABLE-1.
        bus_same = (digitselect == sel_q) && (segments == seg_q);

        cnt_nxt = '0;
        if (bus_same) begin
            cnt_nxt = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 1'b1;
        end
        accept = bus_same && !held && (cnt_nxt == CNT_MAX);

        active    = ~sel_q;
        one_hot   = (active != '0) && ((active & (active - 1'b1)) == '0);
        multi_hot = (active != '0) && !one_hot;
        dec       = decode_seg(~seg_q[7:1]);

        // The completing frame's mask is cleared on the publishing edge.
        cap_nxt    = frame_done ? '0 : captured;
        shadow_nxt = shadow;
        err_nxt    = shadow_err;
        dp_nxt     = shadow_dp;
        if (accept && one_hot) begin
            cap_nxt = cap_nxt | active;
            for (int i = 0; i < NDIGITS; i++) begin
                if (active[i]) begin
                    shadow_nxt[4*i +: 4] = dec[3:0];
                    err_nxt[i]           = dec[4];
                    dp_nxt[i]            = ~seg_q[0];
                end
            end
        end
        done_nxt = accept && one_hot && (&cap_nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q       <= '1;
            seg_q       <= '1;
            stable_cnt  <= '0;
            held        <= 1'b0;
            captured    <= '0;
            shadow      <= '0;
            shadow_err  <= '0;
            shadow_dp   <= '0;
            frame_done  <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            digit_err   <= '0;
            select_err  <= 1'b0;
`ifdef SEVENSEG_DP_CAPTURE_EN
            dp_mask     <= '0;
`endif
        end else begin
            sel_q       <= digitselect;
            seg_q       <= segments;
            stable_cnt  <= cnt_nxt;
            held        <= bus_same ? (held | accept) : 1'b0;
            captured    <= cap_nxt;
            shadow      <= shadow_nxt;
            shadow_err  <= err_nxt;
            shadow_dp   <= dp_nxt;
            frame_done  <= done_nxt;
            select_err  <= accept && multi_hot;
            value_valid <= frame_done;
            if (frame_done) begin
                value     <= shadow;
                digit_err <= shadow_err;
`ifdef SEVENSEG_DP_CAPTURE_EN
                dp_mask   <= shadow_dp;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

    localparam int N  = 8;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] digitselect = '1;
    logic [7:0]   segments = '1;
    logic [4*N-1:0] value;
    logic         value_valid;
    logic [N-1:0] digit_err;
    logic         select_err;
`ifdef SEVENSEG_DP_CAPTURE_EN
    logic [N-1:0] dp_mask;
`endif

    sevenseg_scan_decoder #(.NDIGITS(N), .STABLE_CYCLES(SC)) dut (
        .clk(clk),
        .reset(reset),
        .digitselect(digitselect),
        .segments(segments),
        .value(value),
        .value_valid(value_valid),
        .digit_err(digit_err),
        .select_err(select_err)
`ifdef SEVENSEG_DP_CAPTURE_EN
        ,
        .dp_mask(dp_mask)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] v;
        logic [N-1:0]   e;
        logic [N-1:0]   d;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int exp_sel_err = 0;
    int seen_sel_err = 0;

    logic [6:0] pat_tab [16];

    // Reference model state: the frame being assembled, from the digit rules.
    logic [4*N-1:0] m_shadow;
    logic [N-1:0]   m_err, m_dp, m_cap;
    logic [15:0]    last_bus;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] seg_of(input int nib, input logic dp);
        logic [6:0] p;
        p = pat_tab[nib];
        return ~{p, dp};
    endfunction

    function automatic logic [7:0] sel_of(input int d);
        logic [N-1:0] s;
        s = '1;
        s[d] = 1'b0;
        return s;
    endfunction

    task automatic model_clear();
        m_shadow = '0;
        m_err    = '0;
        m_dp     = '0;
        m_cap    = '0;
        last_bus = 16'hFFFF;
    endtask

    // Drive one bus pattern for len clock edges and update the model.
    task automatic hold(input logic [7:0] sel, input logic [7:0] seg, input int len);
        logic [N-1:0] act;
        int idx;
        int nib;
        logic bad;
        exp_t x;
        if ({sel, seg} == last_bus) begin
            digitselect = sel;
            segments    = seg ^ 8'h01;
            last_bus    = {sel, seg ^ 8'h01};
            @(negedge clk);
        end
        digitselect = sel;
        segments    = seg;
        if (len >= SC) begin
            act = ~sel;
            if (act != '0) begin
                if ($countones(act) == 1) begin
                    idx = 0;
                    for (int i = 0; i < N; i++) if (act[i]) idx = i;
                    nib = 0;
                    bad = 1'b1;
                    for (int k = 0; k < 16; k++) begin
                        if (pat_tab[k] == ~seg[7:1]) begin
                            nib = k;
                            bad = 1'b0;
                        end
                    end
                    m_shadow[4*idx +: 4] = 4'(nib);
                    m_err[idx] = bad;
                    m_dp[idx]  = ~seg[0];
                    m_cap[idx] = 1'b1;
                    if (m_cap == '1) begin
                        x.v = m_shadow;
                        x.e = m_err;
                        x.d = m_dp;
                        q.push_back(x);
                        m_cap = '0;
                    end
                end else begin
                    exp_sel_err++;
                end
            end
        end
        last_bus = {sel, seg};
        repeat (len) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        digitselect = '1;
        segments = '1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic frame_word(input logic [31:0] w, input logic [N-1:0] dps);
        for (int d = 0; d < N; d++) hold(sel_of(d), seg_of(int'(w[4*d +: 4]), dps[d]), SC);
    endtask

    // Monitor: pops the scoreboard whenever the DUT publishes a word.
    always @(negedge clk) begin
        if (!reset) begin
            if (select_err) seen_sel_err++;
            if (value_valid) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_value_valid: got value %h with empty queue", value);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("value", 64'(value), 64'(x.v));
                    chk("digit_err", 64'(digit_err), 64'(x.e));
`ifdef SEVENSEG_DP_CAPTURE_EN
                    chk("dp_mask", 64'(dp_mask), 64'(x.d));
`endif
                end
            end
        end
    end

    initial begin
        logic [7:0] s, g, m;
        logic [31:0] w;
        int kind, d;
        pat_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        model_clear();
        @(negedge clk);
        do_reset();
        chk("reset_value", 64'(value), 64'h0);
        chk("reset_value_valid", 64'(value_valid), 64'h0);
        chk("reset_digit_err", 64'(digit_err), 64'h0);
        chk("reset_select_err", 64'(select_err), 64'h0);

        // Counting frame 0..7.
        frame_word(32'h76543210, 8'h00);
        hold(8'hFF, 8'hFF, 8);

        // DEADBEEF with 3-cycle glitch patterns before each digit.
        w = 32'hDEADBEEF;
        for (int i = 0; i < N; i++) begin
            g = 8'($urandom);
            hold(sel_of(i), g, 3);
            hold(sel_of(i), seg_of(int'(w[4*i +: 4]), 1'b0), SC);
        end

        // Digit 2 shows dp only: undecodable.
        for (int i = 0; i < N; i++)
            hold(sel_of(i), (i == 2) ? 8'hFE : seg_of(10, 1'b0), SC);

        // Two strobes active at once, then a clean frame.
        hold(8'hFC, seg_of(5, 1'b0), SC);
        hold(8'hFF, 8'hFF, 6);
        frame_word(32'h13572468, 8'h00);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 5; i++) hold(sel_of(i), seg_of(3, 1'b0), SC);
        do_reset();
        frame_word(32'h99999999, 8'h00);

        // Decimal points on digits 0 and 7.
        frame_word(32'h0F1E2D3C, 8'b1000_0001);

        // Randomised scanning with glitches, blanks, bad patterns, multi-hot.
        for (int n = 0; n < 500; n++) begin
            kind = $urandom_range(0, 19);
            d = $urandom_range(0, N - 1);
            s = sel_of(d);
            g = seg_of($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            if (kind < 14) begin
                hold(s, g, $urandom_range(SC, SC + 3));
            end else if (kind < 16) begin
                hold(s, {7'($urandom), 1'($urandom)}, SC);
            end else if (kind < 18) begin
                hold(s, 8'($urandom), $urandom_range(1, SC - 1));
            end else if (kind == 18) begin
                hold(8'hFF, 8'($urandom), SC + 1);
            end else begin
                do m = 8'($urandom); while ($countones(~m) < 2);
                hold(m, g, SC);
            end
        end

        hold(8'hFF, 8'hFF, 12);
        chk("queue_drained", 64'(q.size()), 64'h0);
        chk("select_err_pulses", 64'(seen_sel_err), 64'(exp_sel_err));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
Readback monitor for the multiplexed 8-digit active-low 7-segment display bus (digitselect + segments). It samples the scanned bus and debounces each digit strobe. It decodes every segment pattern back to its hex nibble and reassembles the full display word. It sits beside the display driver in self-test and board-bringup builds, so firmware and benches can check what is actually being shown.

Parameters:
NDIGITS, 8, number of scanned digits (digitselect width); value width is 4*NDIGITS.
STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (>=2).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
digitselect  in  NDIGITS  active-low one-hot digit strobe from display driver
segments  in  8  active-low segments; bit7..bit1 = a..g, bit0 = dp
value  out  4*NDIGITS  last complete decoded word; digit i -> value[4i+3:4i]
value_valid  out  1  one-cycle pulse when value updates
digit_err  out  NDIGITS  per-digit flag for the last frame: pattern did not decode
select_err  out  1  one-cycle pulse: non-one-hot, non-blank digitselect accepted as stable

Behaviour:
- Reset: value=0, value_valid=0, digit_err=0, select_err=0, stability counter=0, captured mask=0, shadow word=0, held flag=0.
- Input stage: digitselect and segments registered every cycle (one flop stage, no synchroniser needed; same clock domain).
- Stability: compare registered {digitselect, segments} with previous registered pair. If they are equal, the counter increments, saturating at STABLE_CYCLES-1. Any difference clears the counter and the held flag.
- Acceptance: occurs once per hold, on the edge where the counter reaches STABLE_CYCLES-1 and held=0. At that edge held becomes 1, so there are no repeat captures while the pattern stays put.
- On acceptance, classify digitselect (inverted):
  - All ones inactive (~digitselect==0, blanking): ignored, no action.
  - Exactly one active bit i: decode segments[7:1] (inverted) into shadow nibble i, set captured[i], and record err bit i.
  - More than one active bit: pulse select_err next cycle; shadow and mask are unchanged.
- Decode table (active-high a..g pattern -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 1110111->A, 0011111->b, 1001110->C, 0111101->d, 1001111->E, 1000111->F
  - Any other pattern, including all-off: nibble 0 and err bit set.
  - dp is ignored for decode.
- Frame completion: when an acceptance makes captured all ones, on the next edge:
  - value <= shadow, including the just-accepted nibble.
  - digit_err <= shadow err bits.
  - value_valid = 1 for exactly one cycle.
  - captured cleared.
- Latency: a bus pattern first sampled at edge k is accepted at edge k+STABLE_CYCLES-1. value_valid is high during the cycle after edge k+STABLE_CYCLES.
- Recapturing a digit before the frame completes overwrites its nibble and err bit; this is not an error.
- value and digit_err hold between frames. A new frame starts immediately after completion.
- Reset asserted mid-frame discards the partial frame and clears all outputs on that edge.

Optional Feature:
SEVENSEG_DP_CAPTURE_EN
- Defined: adds output dp_mask [NDIGITS-1:0] (reset 0). The inverted segments[0] is captured per digit alongside the nibble and published with value at frame completion.
- Undefined: no dp_mask port; dp is fully ignored.

Test Plan:
- Reset, then scan digits 0..7 showing 0,1,...,7, each held 4 cycles -> one value_valid pulse; value=32'h76543210; digit_err=0; select_err never high.
- Scan 8 digits showing DEADBEEF (digit7=D ... digit0=F) with 3-cycle glitch segment patterns between digits -> value=32'hDEADBEEF; glitches cause no capture.
- Digit 2 driven segments=8'hFE (active-high dp only), others valid 'A' -> value=32'hAAAAA0AA; digit_err=8'b0000_0100.
- digitselect=8'b1111_1100 held 4 cycles -> select_err one-cycle pulse; no value_valid; next clean frame decodes correctly.
- Reset asserted after 5 of 8 digits, then a full frame of 9s -> single value_valid; value=32'h99999999; no stale nibbles.
- With SEVENSEG_DP_CAPTURE_EN, dp lit on digits 0 and 7 -> dp_mask=8'b1000_0001 with value_valid.
